// File: rtl/instr_fetcher_pkg.sv
// instr_fetcher_pkg: jal opcode and fetch FSM encoding shared by the fetch unit
package instr_fetcher_pkg;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DROP = 2'd2} fetch_state_t;
endpackage

// File: rtl/instr_fetcher_queue.sv
// instr_fetcher_queue: circular FIFO of {pc, instr} with flush, feeding the decoder
module instr_fetcher_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        pop,
  input  logic        flush,
  output logic        full,
  output logic        empty,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head_pc = pc_mem[head];
  assign head_instr = instr_mem[head];
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[tail] <= push_pc;
        instr_mem[tail] <= push_instr;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instr_fetcher.sv
// instr_fetcher: sequential fetch with static jal following, one outstanding request, decoder queue
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_valid,
  output logic [31:0] icache_req_addr,
  input  logic        icache_req_ready,
  input  logic        icache_resp_valid,
  input  logic [31:0] icache_resp_instr,
  output logic        dec_valid,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  input  logic        dec_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  fetch_state_t state;
  logic [31:0] fetch_pc, req_pc, jal_target;
  logic full, empty, accept, push, pop, is_jal;
  assign icache_req_valid = !rst_in && state == S_IDLE && rdy_in && !redirect_valid && !full;
  assign icache_req_addr = fetch_pc;
  assign accept = icache_req_valid && icache_req_ready;
  assign push = icache_resp_valid && state == S_WAIT && !redirect_valid;
  assign dec_valid = !rst_in && !empty && rdy_in;
  assign pop = dec_valid && dec_ready && !redirect_valid;
  assign is_jal = icache_resp_instr[6:0] == OP_JAL;
  assign jal_target = req_pc + {{11{icache_resp_instr[31]}}, icache_resp_instr[31],
                                icache_resp_instr[19:12], icache_resp_instr[20],
                                icache_resp_instr[30:21], 1'b0};
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      state <= (state == S_IDLE || icache_resp_valid) ? S_IDLE : S_DROP;
    end else if (accept) begin
      req_pc <= fetch_pc;
      fetch_pc <= fetch_pc + 32'd4;
      state <= S_WAIT;
    end else if (icache_resp_valid && state != S_IDLE) begin
      if (state == S_WAIT && is_jal) fetch_pc <= jal_target;
      state <= S_IDLE;
    end
  end
  instr_fetcher_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (push),
    .push_pc    (req_pc),
    .push_instr (icache_resp_instr),
    .pop        (pop),
    .flush      (redirect_valid),
    .full       (full),
    .empty      (empty),
    .head_pc    (dec_pc),
    .head_instr (dec_instr)
  );
endmodule
